// File: rtl/bucket_accumulator_if.sv
// bucket_accumulator_if: point type plus the input, drain and adder-side signal bundle.
package bucket_accumulator_pkg;
    typedef struct packed {
        logic [255:0] x;
        logic [255:0] y;
    } curve_point_t;
    localparam curve_point_t inf_point = '1;
endpackage

interface bucket_accumulator_if #(parameter int WINDOW = 4);
    bucket_accumulator_pkg::curve_point_t in_point, out_point, add_P, add_Q, add_R;
    logic in_valid, in_ready, drain_start;
    logic out_valid, out_ready, out_last;
    logic [WINDOW-1:0] in_bucket, out_bucket;
    logic add_reset, add_done, busy, collision;
    modport slave(
        input in_valid, in_point, in_bucket, drain_start, out_ready, add_done, add_R,
        output in_ready, out_valid, out_point, out_bucket, out_last, add_reset, add_P, add_Q, busy, collision
    );
    modport master(
        output in_valid, in_point, in_bucket, drain_start, out_ready, add_done, add_R,
        input in_ready, out_valid, out_point, out_bucket, out_last, add_reset, add_P, add_Q, busy, collision
    );
endinterface

// File: rtl/bucket_accumulator.sv
// bucket_accumulator: MSM bucket registers fed through an external point adder, drained high-to-low.
module bucket_accumulator
    import bucket_accumulator_pkg::*;
#(
    parameter int WINDOW = 4
) (
    input logic clk,
    input logic Reset,
    bucket_accumulator_if.slave bus
);
    localparam int N = 2 ** WINDOW;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DRAIN} state_t;
    state_t state;
    curve_point_t bucket [N];
    curve_point_t p, q, result, sel;
    logic [WINDOW-1:0] idx, drain_idx;
    logic coll;
    assign sel = bucket[bus.in_bucket];
    // Equal x means doubling or negation, which the external adder cannot handle: drop and flag.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            for (int i = 0; i < N; i++) bucket[i] <= inf_point;
            p <= inf_point;
            q <= inf_point;
            result <= inf_point;
            idx <= '0;
            drain_idx <= '0;
            coll <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (bus.drain_start) begin
                        state <= DRAIN;
                        drain_idx <= '1;
                    end else if (bus.in_valid) begin
                        idx <= bus.in_bucket;
                        if (bus.in_point != inf_point) begin
                            if (sel == inf_point) begin
                                result <= bus.in_point;
                                state <= WRITE;
                            end else if (sel.x == bus.in_point.x) begin
                                coll <= 1'b1;
                            end else begin
                                p <= sel;
                                q <= bus.in_point;
                                state <= ISSUE;
                            end
                        end
                    end
                ISSUE: state <= WAIT;
                WAIT:
                    if (bus.add_done) begin
                        result <= bus.add_R;
                        state <= WRITE;
                    end
                WRITE: begin
                    bucket[idx] <= result;
                    state <= IDLE;
                end
                DRAIN:
                    if (bus.out_ready) begin
                        bucket[drain_idx] <= inf_point;
                        drain_idx <= drain_idx - 1'b1;
                        if (drain_idx == WINDOW'(1)) state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready = (state == IDLE) && !Reset;
    assign bus.out_valid = state == DRAIN;
    assign bus.out_point = bucket[drain_idx];
    assign bus.out_bucket = drain_idx;
    assign bus.out_last = (state == DRAIN) && (drain_idx == WINDOW'(1));
    assign bus.add_reset = state != WAIT;
    assign bus.add_P = p;
    assign bus.add_Q = q;
    assign bus.busy = state != IDLE;
    assign bus.collision = coll;
endmodule

// File: tb/tb_bucket_accumulator.sv
// tb_bucket_accumulator: directed and random pushes/drains against a bucket-array reference model.
module tb_bucket_accumulator;
    import bucket_accumulator_pkg::*;
    localparam int WINDOW = 4;
    localparam int NB = 16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    bucket_accumulator_if #(.WINDOW(WINDOW)) bus();
    bucket_accumulator #(.WINDOW(WINDOW)) dut(.clk(clk), .Reset(rst), .bus(bus));

    int stub_cnt = 0;
    int windows = 0;
    logic prev_ar = 1'b1;
    always @(posedge clk) begin
        stub_cnt <= bus.add_reset ? 0 : stub_cnt + 1;
        if (prev_ar && !bus.add_reset) windows <= windows + 1;
        prev_ar <= bus.add_reset;
    end
    assign bus.add_done = !bus.add_reset && stub_cnt >= 5;
    assign bus.add_R.x = bus.add_P.x + bus.add_Q.x;
    assign bus.add_R.y = bus.add_P.y + bus.add_Q.y;

    logic [255:0] mx [NB];
    logic [255:0] my [NB];
    bit mcoll;
    int checks = 0, errors = 0;
    logic [3:0] pattern = 4'b1001;

    task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            mx[i] = '1;
            my[i] = '1;
        end
        mcoll = 0;
    endtask

    task automatic model_push(logic [255:0] x, logic [255:0] y, int b);
        if ({x, y} == inf_point) return;
        if ({mx[b], my[b]} == inf_point) begin
            mx[b] = x;
            my[b] = y;
        end else if (mx[b] == x) mcoll = 1;
        else begin
            mx[b] = mx[b] + x;
            my[b] = my[b] + y;
        end
    endtask

    task automatic push(logic [255:0] x, logic [255:0] y, logic [3:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("push_timeout", 0, 1);
        bus.in_valid = 1;
        bus.in_point = {x, y};
        bus.in_bucket = b;
        @(posedge clk);
        #1 bus.in_valid = 0;
        model_push(x, y, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("idle_timeout", 0, 1);
    endtask

    task automatic start_drain();
        wait_idle();
        check("collision", bus.collision, mcoll);
        bus.drain_start = 1;
        @(posedge clk);
        #1 bus.drain_start = 0;
    endtask

    task automatic collect(bit pat);
        int e = NB - 1, k = 0, cyc = 0;
        bit stalled = 0;
        curve_point_t held;
        logic [3:0] hb;
        while (e >= 1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold_point", bus.out_point, held);
                check("hold_bucket", bus.out_bucket, hb);
            end
            bus.out_ready = (pat && k < 4) ? pattern[3-k] : 1'($urandom % 2);
            k++;
            check("out_valid", bus.out_valid, 1);
            check("in_ready_drain", bus.in_ready, 0);
            if (bus.out_ready) begin
                check("out_bucket", bus.out_bucket, e);
                check("out_point", bus.out_point, {mx[e], my[e]});
                check("out_last", bus.out_last, e == 1);
                mx[e] = '1;
                my[e] = '1;
                e--;
                stalled = 0;
            end else begin
                stalled = 1;
                held = bus.out_point;
                hb = bus.out_bucket;
            end
        end
        if (cyc >= 300) check("drain_timeout", 0, 1);
        @(negedge clk);
        bus.out_ready = 0;
        check("drain_end_valid", bus.out_valid, 0);
        check("drain_end_ready", bus.in_ready, 1);
    endtask

    task automatic drain(bit pat);
        start_drain();
        collect(pat);
    endtask

    initial begin
        int w0, n;
        logic [255:0] rx;
        bus.in_valid = 0;
        bus.in_point = '0;
        bus.in_bucket = '0;
        bus.drain_start = 0;
        bus.out_ready = 0;
        model_clear();
        rst = 1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_add_reset", bus.add_reset, 1);
        check("rst_collision", bus.collision, 0);
        check("rst_add_P", bus.add_P, inf_point);
        check("rst_add_Q", bus.add_Q, inf_point);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;

        w0 = windows;
        push(3, 4, 2);
        check("fast_write_busy", bus.busy, 1);
        check("fast_write_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 check("fast_ready_again", bus.in_ready, 1);
        push(5, 6, 2);
        check("issue_add_reset", bus.add_reset, 1);
        check("issue_add_P", bus.add_P, {256'd3, 256'd4});
        check("issue_add_Q", bus.add_Q, {256'd5, 256'd6});
        @(posedge clk);
        #1 check("wait_add_reset", bus.add_reset, 0);
        wait_idle();
        check("one_window", windows - w0, 1);
        drain(0);

        push('1, '1, 5);
        check("discard_ready", bus.in_ready, 1);
        check("discard_busy", bus.busy, 0);
        push(7, 1, 0);
        drain(0);

        w0 = windows;
        push(9, 2, 1);
        push(9, 3, 1);
        wait_idle();
        check("collision_set", bus.collision, 1);
        check("collision_no_add", windows - w0, 0);
        drain(0);
        check("collision_sticky", bus.collision, 1);

        for (int i = 0; i < 6; i++) push(256'($urandom), 256'($urandom), 4'($urandom_range(1, 15)));
        drain(1);
        drain(0);

        wait_idle();
        @(negedge clk);
        bus.drain_start = 1;
        bus.in_valid = 1;
        bus.in_point = {256'd11, 256'd12};
        bus.in_bucket = 3;
        @(posedge clk);
        #1 bus.drain_start = 0;
        check("prio_drain", bus.out_valid, 1);
        collect(0);
        @(posedge clk);
        #1 bus.in_valid = 0;
        model_push(11, 12, 3);
        drain(0);

        push(1, 1, 4);
        push(2, 3, 4);
        n = 0;
        @(negedge clk);
        while (bus.add_reset && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("wait_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_add_reset", bus.add_reset, 1);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_collision", bus.collision, 0);
        model_clear();
        @(negedge clk) rst = 0;
        drain(0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                rx = 256'($urandom_range(1, 6));
                if ($urandom % 8 == 0) push('1, '1, 4'($urandom));
                else push(rx, 256'($urandom), 4'($urandom));
            end
            drain(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bucket_accumulator.md
# bucket_accumulator

Upstream controller for the MSM bucket method. It takes a stream of (point, bucket index) pairs and keeps 2^WINDOW bucket registers, all initialised to `inf_point`. For each accepted pair it drives an external `point_add` instance to compute bucket + point, then writes the result back. On request it drains buckets 2^WINDOW-1 down to 1 to the running-sum stage, clearing each bucket as it goes.

## Interface
- `WINDOW`, default 4: bucket index width. There are 2^WINDOW buckets; bucket 0 is never drained.
- `clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the input pair is valid.
- `in_ready`  out  1  the block can accept a pair this cycle.
- `in_point`  in  curve_point_t  affine point to accumulate.
- `in_bucket`  in  WINDOW  target bucket index.
- `drain_start`  in  1  single-cycle request to drain all buckets.
- `out_valid`  out  1  drained bucket is valid.
- `out_ready`  in  1  downstream accepts the drained bucket.
- `out_point`  out  curve_point_t  drained bucket value.
- `out_bucket`  out  WINDOW  index of the drained bucket.
- `out_last`  out  1  high with bucket 1, the final drained word.
- `add_reset`  out  1  drives `point_add` `Reset`; held high while the adder is idle.
- `add_P`, `add_Q`  out  curve_point_t  adder operands (P = bucket, Q = input point); registered.
- `add_done`  in  1  `point_add` `Done`.
- `add_R`  in  curve_point_t  `point_add` result.
- `busy`  out  1  state is not IDLE.
- `collision`  out  1  sticky flag for an equal-x drop; cleared only by `Reset`.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DRAIN.
- **IDLE**
  - `in_ready` = 1.
  - `drain_start` has priority over `in_valid` in the same cycle. On `drain_start`: go to DRAIN, set the drain index to 2^WINDOW-1, and do not accept the input.
  - On `in_valid & in_ready`, capture `idx <= in_bucket`, `P <= bucket[in_bucket]`, `Q <= in_point`, then classify:
    - `in_point == inf_point`: discard and stay in IDLE.
    - `P == inf_point`: fast path to WRITE with result = `Q`. The adder is not used.
    - `P.x == Q.x` (doubling or negation, which `point_add` cannot do): set `collision`, drop the point, stay in IDLE.
    - Otherwise: go to ISSUE.
- **ISSUE**: exactly one cycle with `add_reset` = 1 and `add_P`/`add_Q` stable. Go to WAIT.
- **WAIT**: `add_reset` = 0. Stay until `add_done` = 1, then latch the result from `add_R` and go to WRITE. There is no timeout.
- **WRITE**: `bucket[idx] <= result`, go to IDLE.
- **DRAIN**
  - `out_valid` = 1; `out_point` = `bucket[drain_idx]`; `out_bucket` = `drain_idx`; `out_last` = (`drain_idx` == 1).
  - On `out_valid & out_ready`: `bucket[drain_idx] <= inf_point` and decrement `drain_idx`.
  - After the transfer with `out_last`, go to IDLE.
  - `in_ready` = 0 throughout. `drain_start` is ignored outside IDLE.
- `add_reset` = 1 in every state except WAIT.
- `add_P`/`add_Q` hold their value outside ISSUE and WAIT.
- Buckets are plain registers: 2^WINDOW × 512 bits. There is no arithmetic in this block except the index decrement.
- `Reset`, including mid-operation:
  - Asynchronously forces state = IDLE and all buckets = `inf_point`.
  - Clears `collision`, `idx`, and `drain_idx`.
  - Drives `add_reset` = 1.
  - Any in-flight addition or drain is abandoned.

## Timing
- Outputs while `Reset` is high: `in_ready` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `add_reset` = 1, `collision` = 0, `add_P` = `add_Q` = `inf_point`.
- `in_ready`, `out_valid`, `out_*`, and `busy` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- Adder path, with acceptance at edge T:
  - ISSUE is cycle T+1.
  - WAIT begins at T+2.
  - If `add_done` is first sampled high at edge D, WRITE occupies the cycle after D.
  - The bucket is updated at the end of WRITE.
  - `in_ready` is high again in the cycle after WRITE.
- Fast path: WRITE is cycle T+1; `in_ready` is high at T+2. Minimum issue interval is 2 cycles.
- Discard and collision paths: `in_ready` stays high; the next pair can be accepted at T+1.
- Read-after-write: a pair accepted in the cycle right after WRITE sees the updated bucket.
- Drain: 2^WINDOW-1 transfers, one per cycle when `out_ready` is held high. `out_*` holds stable while `out_valid & ~out_ready`.

## Test plan
Use a stub adder: `add_done` rises 5 cycles after `add_reset` falls, and `add_R` = {P.x+Q.x, P.y+Q.y} mod 2^256.
- **Fast path then add.** After reset, push {x=3,y=4} to bucket 2, then {x=5,y=6} to bucket 2, then drain.
  - Expect one `add_reset` low window.
  - Bucket 2 drains as {8,10}.
  - All other buckets drain as `inf_point`.
- **Discard and bucket 0.** Push `inf_point` to bucket 5, then {x=7,y=1} to bucket 0, then drain.
  - Expect `in_ready` to stay high after the `inf_point` push.
  - Expect 15 transfers in the order 15…1 with `out_last` only on bucket 1; bucket 0 is never output.
- **Collision.** Push {x=9,y=2} then {x=9,y=3}, both to bucket 1.
  - Expect `collision` = 1 and sticky.
  - Bucket 1 drains as {9,2}.
  - The adder is never released from reset.
- **Drain backpressure and clear.** During a drain, toggle `out_ready` 1,0,0,1.
  - Expect `out_*` to hold stable while stalled and no duplicate or skipped indices.
  - A second drain outputs all `inf_point`.
- **Drain/input priority.** Assert `drain_start` and `in_valid` in the same IDLE cycle.
  - Expect the drain to start and the input not to be accepted (no handshake).
  - The input is accepted after `out_last`.
- **Reset mid-WAIT.** Assert `Reset` 2 cycles into WAIT.
  - Expect immediate IDLE, `add_reset` = 1, and all buckets `inf_point` on the next drain.
